// File: rtl/count_day.sv
// BCD day-of-month counter for the century clock chain. Advances on the daily
// carry, wraps at the month length chosen by T/TO/TN/leap, and emits the month carry.
module count_day #(
  parameter int MAX_DISPLAY_UNIT = 4,
  parameter int MAX_DISPLAY_TEN  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_d,
  input  logic                        set_mode,
  input  logic                        up,
  input  logic                        down,
  input  logic                        T,
  input  logic                        TO,
  input  logic                        TN,
  input  logic                        leap,
  output logic [MAX_DISPLAY_UNIT-1:0] day_unit,
  output logic [MAX_DISPLAY_TEN-1:0]  day_ten,
  output logic                        pulse_d,
  output logic                        last_day
);

  logic [MAX_DISPLAY_UNIT-1:0] day_unit_q, day_unit_d;
  logic [MAX_DISPLAY_TEN-1:0]  day_ten_q, day_ten_d;
  logic                        up_q, down_q;

  logic [MAX_DISPLAY_UNIT-1:0] max_unit;
  logic [MAX_DISPLAY_TEN-1:0]  max_ten;
  logic [5:0]                  max_val;
  logic [5:0]                  day_val;
  logic                        day_valid;
  logic                        up_rise, down_rise;

  logic [MAX_DISPLAY_UNIT-1:0] inc_unit, dec_unit;
  logic [MAX_DISPLAY_TEN-1:0]  inc_ten, dec_ten;

  // Month length as BCD digits; TN outranks TO, TO outranks T, anything else is 31.
  always_comb begin
    max_ten  = MAX_DISPLAY_TEN'(3);
    max_unit = MAX_DISPLAY_UNIT'(1);
    casez ({TN, TO, T})
      3'b1??: begin
        max_ten  = MAX_DISPLAY_TEN'(2);
        max_unit = leap ? MAX_DISPLAY_UNIT'(9) : MAX_DISPLAY_UNIT'(8);
      end
      3'b01?: begin
        max_ten  = MAX_DISPLAY_TEN'(3);
        max_unit = MAX_DISPLAY_UNIT'(0);
      end
      default: begin
        max_ten  = MAX_DISPLAY_TEN'(3);
        max_unit = MAX_DISPLAY_UNIT'(1);
      end
    endcase
  end

  assign max_val = 6'(max_ten) * 6'd10 + 6'(max_unit);
  assign day_val = 6'(day_ten_q) * 6'd10 + 6'(day_unit_q);

  assign day_valid = (day_unit_q <= MAX_DISPLAY_UNIT'(9)) &&
                     (day_val >= 6'd1) && (day_val <= max_val);
  assign last_day  = (day_val == max_val);
  assign pulse_d   = en_d & ~set_mode & last_day & day_valid;

  assign up_rise   = up & ~up_q;
  assign down_rise = down & ~down_q;

  // Increment step, shared by normal counting and manual up.
  always_comb begin
    inc_unit = day_unit_q + MAX_DISPLAY_UNIT'(1);
    inc_ten  = day_ten_q;
    if (last_day) begin
      inc_unit = MAX_DISPLAY_UNIT'(1);
      inc_ten  = '0;
    end else if (day_unit_q == MAX_DISPLAY_UNIT'(9)) begin
      inc_unit = '0;
      inc_ten  = day_ten_q + MAX_DISPLAY_TEN'(1);
    end
  end

  // Decrement step; day 01 wraps back to the month's last day.
  always_comb begin
    dec_unit = day_unit_q - MAX_DISPLAY_UNIT'(1);
    dec_ten  = day_ten_q;
    if (day_val == 6'd1) begin
      dec_unit = max_unit;
      dec_ten  = max_ten;
    end else if (day_unit_q == '0) begin
      dec_unit = MAX_DISPLAY_UNIT'(9);
      dec_ten  = day_ten_q - MAX_DISPLAY_TEN'(1);
    end
  end

  always_comb begin
    day_unit_d = day_unit_q;
    day_ten_d  = day_ten_q;
    if (!day_valid) begin
      day_unit_d = MAX_DISPLAY_UNIT'(1);
      day_ten_d  = '0;
    end else if (!set_mode) begin
      if (en_d) begin
        day_unit_d = inc_unit;
        day_ten_d  = inc_ten;
      end
    end else if (up_rise && !down_rise) begin
      day_unit_d = inc_unit;
      day_ten_d  = inc_ten;
    end else if (down_rise && !up_rise) begin
      day_unit_d = dec_unit;
      day_ten_d  = dec_ten;
    end
  end

  // Button history tracks in every mode so a level held across a mode switch never steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_unit_q <= MAX_DISPLAY_UNIT'(1);
      day_ten_q  <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      day_unit_q <= day_unit_d;
      day_ten_q  <= day_ten_d;
      up_q       <= up;
      down_q     <= down;
    end
  end

  assign day_unit = day_unit_q;
  assign day_ten  = day_ten_q;

endmodule

// File: tb/tb_count_day.sv
// Directed bench for count_day: an integer day model checked every cycle,
// plus hand-computed literal expectations along the test plan.
module tb_count_day;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en_d = 1'b0, set_mode = 1'b0, up = 1'b0, down = 1'b0;
  logic       T = 1'b1, TO = 1'b0, TN = 1'b0, leap = 1'b0;
  logic [3:0] day_unit;
  logic [1:0] day_ten;
  logic       pulse_d, last_day;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  int m_day = 1;
  bit m_up = 1'b0, m_down = 1'b0;

  count_day #(.MAX_DISPLAY_UNIT(4), .MAX_DISPLAY_TEN(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_d(en_d), .set_mode(set_mode),
    .up(up), .down(down), .T(T), .TO(TO), .TN(TN), .leap(leap),
    .day_unit(day_unit), .day_ten(day_ten), .pulse_d(pulse_d), .last_day(last_day)
  );

  always #5 clk = ~clk;

  function automatic int mmax();
    if (TN) return leap ? 29 : 28;
    if (TO) return 30;
    return 31;
  endfunction

  function automatic int dayv();
    return int'(day_ten) * 10 + int'(day_unit);
  endfunction

  // Model: the day as a plain integer, stepped by the calendar rules.
  always @(posedge clk or negedge rst_n) begin : model
    int mx, nd;
    bit v, ur, dr;
    if (!rst_n) begin
      m_day  <= 1;
      m_up   <= 1'b0;
      m_down <= 1'b0;
    end else begin
      mx = mmax();
      v  = (m_day >= 1) && (m_day <= mx);
      ur = up && !m_up;
      dr = down && !m_down;
      nd = m_day;
      if (!v) nd = 1;
      else if (!set_mode) begin
        if (en_d) nd = (m_day == mx) ? 1 : m_day + 1;
      end else if (ur && !dr) nd = (m_day == mx) ? 1 : m_day + 1;
      else if (dr && !ur) nd = (m_day == 1) ? mx : m_day - 1;
      m_day  <= nd;
      m_up   <= up;
      m_down <= down;
    end
  end

  always @(negedge clk) begin : compare
    int mx, eu, et;
    bit el, ep, v;
    if (cmp_en) begin
      mx = mmax();
      v  = (m_day >= 1) && (m_day <= mx);
      eu = m_day % 10;
      et = m_day / 10;
      el = (m_day == mx);
      ep = en_d && !set_mode && el && v;
      total++;
      if (int'(day_unit) != eu || int'(day_ten) != et || last_day != el || pulse_d != ep) begin
        bad++;
        $display("FAIL model t=%0t: got ten=%0d unit=%0d last=%0b pulse=%0b want ten=%0d unit=%0d last=%0b pulse=%0b",
                 $time, day_ten, day_unit, last_day, pulse_d, et, eu, el, ep);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end else begin
      $display("check %s: %0d", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to(input int target);
    int n;
    n = 0;
    en_d = 1'b1;
    while (dayv() != target && n < 40) begin
      tick();
      n++;
    end
    en_d = 1'b0;
    if (n >= 40) chk("advance_timeout", dayv(), target);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    #7;
    chk("rst_day", dayv(), 1);
    chk("rst_pulse", int'(pulse_d), 0);
    chk("rst_last", int'(last_day), 0);
    #12 rst_n = 1'b1;
    tick();

    // 31-day month: 01..31 then wrap with a single carry.
    T = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      en_d = 1'b1;
      @(negedge clk);
      chk($sformatf("seq_day%0d", i), dayv(), i);
      chk($sformatf("seq_pulse%0d", i), int'(pulse_d), (i == 31) ? 1 : 0);
      if (i == 10 || i == 20 || i == 30) chk($sformatf("seq_ten%0d", i), int'(day_ten), i / 10);
      tick();
    end
    en_d = 1'b0;
    chk("wrap31", dayv(), 1);

    // February, non-leap then leap.
    T = 1'b0; TN = 1'b1; leap = 1'b0;
    advance_to(28);
    en_d = 1'b1;
    @(negedge clk);
    chk("feb28_pulse", int'(pulse_d), 1);
    tick();
    en_d = 1'b0;
    chk("feb28_wrap", dayv(), 1);
    leap = 1'b1;
    advance_to(28);
    en_d = 1'b1;
    @(negedge clk);
    chk("leap28_pulse", int'(pulse_d), 0);
    tick();
    chk("leap29_day", dayv(), 29);
    @(negedge clk);
    chk("leap29_pulse", int'(pulse_d), 1);
    tick();
    en_d = 1'b0;
    chk("leap29_wrap", dayv(), 1);

    // Month change to a shorter month forces 01 without a carry.
    TN = 1'b0; leap = 1'b0; T = 1'b1;
    advance_to(31);
    T = 1'b0; TO = 1'b1;
    @(negedge clk);
    chk("d31_to_pulse", int'(pulse_d), 0);
    tick();
    chk("d31_to_force", dayv(), 1);
    advance_to(30);
    TO = 1'b0; TN = 1'b1;
    tick();
    chk("d30_tn_force", dayv(), 1);

    // Set mode in a 30-day month.
    TN = 1'b0; TO = 1'b1; set_mode = 1'b1;
    down = 1'b1;
    tick();
    chk("set_down_wrap", dayv(), 30);
    en_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("set_en_pulse", int'(pulse_d), 0);
      tick();
    end
    en_d = 1'b0;
    chk("set_en_hold", dayv(), 30);
    down = 1'b0;
    up = 1'b1;
    repeat (5) tick();
    chk("set_up_once", dayv(), 1);
    up = 1'b0;
    tick();
    up = 1'b1; down = 1'b1;
    tick();
    chk("set_both", dayv(), 1);
    up = 1'b0; down = 1'b0;
    set_mode = 1'b0;
    up = 1'b1;
    tick();
    set_mode = 1'b1;
    tick();
    tick();
    chk("mode_switch_up", dayv(), 1);
    up = 1'b0; set_mode = 1'b0;
    tick();

    // Multi-hot flags resolve to February, all-zero to 31.
    T = 1'b1; TO = 1'b1; TN = 1'b1; leap = 1'b0;
    advance_to(28);
    @(negedge clk);
    chk("multihot_last", int'(last_day), 1);
    en_d = 1'b1;
    tick();
    en_d = 1'b0;
    chk("multihot_wrap", dayv(), 1);
    T = 1'b0; TO = 1'b0; TN = 1'b0;
    advance_to(31);
    @(negedge clk);
    chk("zero_last", int'(last_day), 1);
    en_d = 1'b1;
    tick();
    en_d = 1'b0;
    chk("zero_wrap", dayv(), 1);

    // Asynchronous reset mid-count.
    T = 1'b1;
    advance_to(17);
    en_d = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_day", dayv(), 1);
    chk("midrst_pulse", int'(pulse_d), 0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_count", dayv(), 2);
    en_d = 1'b0;
    tick();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
